// File: rtl/serial_xnor_compare.sv
// Serial bit-pair comparator: streams WIDTH A/B pairs (LSB first) and reports
// whether the frame matched, how many pairs differed and where the first difference was.
module serial_xnor_compare #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH + 1),
   localparam int IW    = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          A,
   input  logic          B,
   input  logic          bit_valid,
   output logic          busy,
   output logic          done,
   output logic          equal,
   output logic [CW-1:0] mism_cnt,
   output logic          first_vld,
   output logic [IW-1:0] first_idx
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
   localparam logic [CW-1:0] MISM_MAX = CW'(WIDTH);

   state_t          state_q, state_d;
   logic [IW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]   mism_q, mism_d;
   logic            fvld_q, fvld_d;
   logic [IW-1:0]   fidx_q, fidx_d;
   logic            equal_q, equal_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            match_s;
   logic            last_s;
   logic [CW-1:0]   mism_inc_s;

   assign match_s    = ~(A ^ B);
   assign last_s     = (bit_cnt_q == LAST_IDX);
   assign mism_inc_s = (mism_q == MISM_MAX) ? mism_q : (mism_q + CW'(1));

   // Next-state and result update; busy/done are derived from the next state so they leave a flop.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      mism_d    = mism_q;
      fvld_d    = fvld_q;
      fidx_d    = fidx_q;
      equal_d   = equal_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_RUN;
               bit_cnt_d = IW'(0);
               mism_d    = CW'(0);
               fvld_d    = 1'b0;
               fidx_d    = IW'(0);
               equal_d   = 1'b0;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bit_valid) begin
               mism_d = match_s ? mism_q : mism_inc_s;
               if (!match_s && !fvld_q) begin
                  fvld_d = 1'b1;
                  fidx_d = bit_cnt_q;
               end else begin
                  fvld_d = fvld_q;
                  fidx_d = fidx_q;
               end
               // The final pair is folded into equal on the same edge that enters DONE.
               if (last_s) begin
                  bit_cnt_d = IW'(0);
                  state_d   = ST_DONE;
                  equal_d   = (mism_d == CW'(0));
               end else begin
                  bit_cnt_d = bit_cnt_q + IW'(1);
                  state_d   = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= IW'(0);
         mism_q    <= CW'(0);
         fvld_q    <= 1'b0;
         fidx_q    <= IW'(0);
         equal_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         mism_q    <= mism_d;
         fvld_q    <= fvld_d;
         fidx_q    <= fidx_d;
         equal_q   <= equal_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign equal     = equal_q;
   assign mism_cnt  = mism_q;
   assign first_vld = fvld_q;
   assign first_idx = fidx_q;

endmodule

// File: tb/tb_serial_xnor_compare.sv
// Bench for serial_xnor_compare (WIDTH=8): table of frames plus reset/hold sequences,
// with frame results checked through a scoreboard queue popped on each done pulse.
module tb_serial_xnor_compare;

   localparam int WIDTH = 8;
   localparam int CW    = 4;
   localparam int IW    = 3;

   logic          clk = 1'b0;
   logic          rst, start, A, B, bit_valid;
   logic          busy, done, equal, first_vld;
   logic [CW-1:0] mism_cnt;
   logic [IW-1:0] first_idx;

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int mism;
      bit vld;
      int idx;
      bit eq;
   } res_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      bit         stall;
      bit         xstart;
      res_t       exp;
      int         lat;
   } vec_t;

   res_t sb_q[$];
   res_t mon_e;
   vec_t vecs[6];

   always #5 clk = ~clk;

   serial_xnor_compare #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .bit_valid(bit_valid),
      .busy(busy), .done(done), .equal(equal), .mism_cnt(mism_cnt),
      .first_vld(first_vld), .first_idx(first_idx)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
      res_t       r;
      logic [7:0] x;
      x = a ^ b;
      r.mism = 0; r.vld = 1'b0; r.idx = 0;
      for (int i = 0; i < 8; i++) begin
         if (x[i]) begin
            r.mism++;
            if (!r.vld) begin
               r.vld = 1'b1;
               r.idx = i;
            end
         end
      end
      r.eq = (r.mism == 0);
      return r;
   endfunction

   function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input bit stall,
                               input bit xs, input int mism, input bit vld, input int idx,
                               input bit eq, input int lat);
      vec_t v;
      v.a = a; v.b = b; v.stall = stall; v.xstart = xs;
      v.exp.mism = mism; v.exp.vld = vld; v.exp.idx = idx; v.exp.eq = eq;
      v.lat = lat;
      return v;
   endfunction

   // Scoreboard side: every done pulse must match the oldest expected frame result.
   always @(posedge clk) begin
      #2;
      if (mon_en) begin
         chk("busy_done_overlap", int'(busy & done), 0);
         if (done) begin
            chk("done_expected", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
               mon_e = sb_q.pop_front();
               chk("sb_mism",  int'(mism_cnt),  mon_e.mism);
               chk("sb_fvld",  int'(first_vld), int'(mon_e.vld));
               chk("sb_fidx",  int'(first_idx), mon_e.idx);
               chk("sb_equal", int'(equal),     int'(mon_e.eq));
            end
         end
      end
   end

   task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input bit stall,
                            input bit xstart, input res_t exp, input int exp_lat);
      int i;
      int cyc;
      bit ph;
      bit got;
      sb_q.push_back(exp);
      start = 1'b1;
      bit_valid = 1'b0;
      tick;
      start = xstart;
      chk("start_busy",      int'(busy),      1);
      chk("start_clr_equal", int'(equal),     0);
      chk("start_clr_mism",  int'(mism_cnt),  0);
      chk("start_clr_fvld",  int'(first_vld), 0);
      chk("start_clr_fidx",  int'(first_idx), 0);
      i = 0; ph = 1'b0; got = 1'b0; cyc = 1;
      while (!got && cyc < 40) begin
         if (i < 8 && !(stall && ph)) begin
            bit_valid = 1'b1;
            A = a[i];
            B = b[i];
         end else begin
            bit_valid = 1'b0;
            A = 1'($urandom);
            B = 1'($urandom);
         end
         tick;
         cyc++;
         if (bit_valid) i++;
         ph  = ~ph;
         got = done;
      end
      chk("done_seen", int'(got), 1);
      chk("latency",   cyc,       exp_lat);
      // DONE cycle: stray start and pairs must have no effect.
      bit_valid = 1'($urandom);
      A = 1'($urandom);
      B = 1'($urandom);
      tick;
      start = 1'b0;
      bit_valid = 1'b0;
      chk("done_to_idle_busy", int'(busy), 0);
      chk("done_one_cycle",    int'(done), 0);
      tick;
      chk("idle_stays",  int'(busy),     0);
      chk("after_mism",  int'(mism_cnt), exp.mism);
      chk("after_equal", int'(equal),    int'(exp.eq));
   endtask

   initial begin
      vecs[0] = mk(8'b10110010, 8'b10110010, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 9);
      vecs[1] = mk(8'b10110010, 8'b10100011, 1'b0, 1'b0, 2, 1'b1, 0, 1'b0, 9);
      vecs[2] = mk(8'h55,       8'hAA,       1'b1, 1'b0, 8, 1'b1, 0, 1'b0, 16);
      vecs[3] = mk(8'h3C,       8'h18,       1'b0, 1'b1, 2, 1'b1, 2, 1'b0, 9);
      vecs[4] = mk(8'h00,       8'h00,       1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 16);
      vecs[5] = mk(8'h0F,       8'h8F,       1'b0, 1'b0, 1, 1'b1, 7, 1'b0, 9);

      // Reset with start and bit_valid held high: reset must win.
      rst = 1'b1; start = 1'b1; A = 1'b0; B = 1'b1; bit_valid = 1'b1;
      tick;
      tick;
      chk("rst_busy",  int'(busy),      0);
      chk("rst_done",  int'(done),      0);
      chk("rst_equal", int'(equal),     0);
      chk("rst_mism",  int'(mism_cnt),  0);
      chk("rst_fvld",  int'(first_vld), 0);
      chk("rst_fidx",  int'(first_idx), 0);
      rst = 1'b0; start = 1'b0; bit_valid = 1'b0;
      mon_en = 1'b1;
      tick;
      chk("idle_after_rst", int'(busy), 0);

      for (int k = 0; k < 6; k++) begin
         run_frame(vecs[k].a, vecs[k].b, vecs[k].stall, vecs[k].xstart, vecs[k].exp, vecs[k].lat);
      end

      // Result of the last frame must hold through idle traffic without start.
      for (int k = 0; k < 20; k++) begin
         A = 1'($urandom); B = 1'($urandom); bit_valid = 1'($urandom);
         tick;
      end
      bit_valid = 1'b0;
      chk("hold_mism",  int'(mism_cnt),  vecs[5].exp.mism);
      chk("hold_fidx",  int'(first_idx), vecs[5].exp.idx);
      chk("hold_fvld",  int'(first_vld), int'(vecs[5].exp.vld));
      chk("hold_equal", int'(equal),     int'(vecs[5].exp.eq));
      chk("hold_busy",  int'(busy),      0);

      // Abort mid-frame after 4 pairs (mismatch at index 1); no done may follow.
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bit_valid = 1'b1;
         A = (k == 1) ? 1'b1 : 1'b0;
         B = 1'b0;
         tick;
      end
      chk("mid_busy", int'(busy),      1);
      chk("mid_mism", int'(mism_cnt),  1);
      chk("mid_fvld", int'(first_vld), 1);
      chk("mid_fidx", int'(first_idx), 1);
      rst = 1'b1; start = 1'b1;
      tick;
      rst = 1'b0; start = 1'b0; bit_valid = 1'b0;
      chk("abort_busy",  int'(busy),      0);
      chk("abort_done",  int'(done),      0);
      chk("abort_equal", int'(equal),     0);
      chk("abort_mism",  int'(mism_cnt),  0);
      chk("abort_fvld",  int'(first_vld), 0);
      chk("abort_fidx",  int'(first_idx), 0);
      for (int k = 0; k < 10; k++) begin
         bit_valid = 1'($urandom); A = 1'($urandom); B = 1'($urandom);
         tick;
      end
      bit_valid = 1'b0;
      run_frame(8'hC3, 8'hC3, 1'b0, 1'b0, model(8'hC3, 8'hC3), 9);

      // Random frames checked against the reference model.
      for (int k = 0; k < 6; k++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         ra = 8'($urandom);
         rb = 8'($urandom);
         run_frame(ra, rb, 1'b0, 1'b0, model(ra, rb), 9);
      end

      tick;
      chk("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
